// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch front end: sequential fetch, credit-limited requests, in-order queue, redirect flush
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_addr,
  output logic        req_vld,
  output logic        req_rnw,
  output logic [31:0] req_addr,
  output logic [31:0] req_data,
  input  logic        req_ack,
  input  logic        rsp_vld,
  input  logic [31:0] rsp_addr,
  input  logic [31:0] rsp_data,
  output logic        rsp_ack,
  output logic        inst_vld,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        inst_ack
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [CW-1:0] QDEPTH_C = QDEPTH[CW-1:0];
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  logic          run_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   q_pc_q   [QDEPTH];
  logic [31:0]   q_data_q [QDEPTH];

  logic          req_fire, rsp_fire, pop, discard, push;
  logic [CW:0]   credit_used;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^redirect_addr[1:0];

  // Queue slots are reserved at request time, so a response always finds room.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
  assign req_vld     = run_q && (credit_used < {1'b0, QDEPTH_C});
  assign req_rnw     = 1'b1;
  assign req_addr    = fetch_pc_q;
  assign req_data    = 32'h0;
  assign rsp_ack     = run_q;
  assign inst_vld    = (count_q != '0);
  assign inst_pc     = q_pc_q[rd_ptr_q];
  assign inst_data   = q_data_q[rd_ptr_q];

  assign req_fire = req_vld && req_ack;
  assign rsp_fire = rsp_vld && rsp_ack;
  assign pop      = inst_vld && inst_ack;
  assign discard  = rsp_fire && ((drop_cnt_q != '0) || redirect_vld);
  assign push     = rsp_fire && !discard;

  always_comb begin
    outstanding_d = outstanding_q;
    if (req_fire && !rsp_fire)      outstanding_d = outstanding_q + CNT_ONE;
    else if (!req_fire && rsp_fire) outstanding_d = outstanding_q - CNT_ONE;

    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect_vld) begin
      // Everything still in flight belongs to the old stream, including a same-cycle accept.
      fetch_pc_d = {redirect_addr[31:2], 2'b00};
      drop_cnt_d = outstanding_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_ONE;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_q[i]   <= 32'h0;
        q_data_q[i] <= 32'h0;
      end
    end else begin
      run_q         <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      if (push) begin
        q_pc_q[wr_ptr_q]   <= rsp_addr;
        q_data_q[wr_ptr_q] <= rsp_data;
      end
    end
  end

  assert property (@(posedge clock) disable iff (!reset) !(push && (count_q == QDEPTH_C)));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - randomized self-checking bench for riscv_fetch_unit with a queue-based fetch model
module tb_riscv_fetch_unit;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int          QD  = 4;

  logic        clock, reset;
  logic        redirect_vld, req_vld, req_rnw, req_ack, rsp_vld, rsp_ack;
  logic        inst_vld, inst_ack;
  logic [31:0] redirect_addr, req_addr, req_data, rsp_addr, rsp_data, inst_pc, inst_data;

  riscv_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clock(clock), .reset(reset),
    .redirect_vld(redirect_vld), .redirect_addr(redirect_addr),
    .req_vld(req_vld), .req_rnw(req_rnw), .req_addr(req_addr), .req_data(req_data),
    .req_ack(req_ack),
    .rsp_vld(rsp_vld), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
    .inst_vld(inst_vld), .inst_pc(inst_pc), .inst_data(inst_data), .inst_ack(inst_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Driver side: accepted requests awaiting their response, served in order.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          edge_n = 0;
  int          lat_min = 2, lat_max = 2, ack_pct = 100, iack_pct = 100;
  bit          hold_rsp = 0;

  // Fetch model: instruction stream state and the decode-visible queue.
  logic [31:0] m_q[$];
  logic [31:0] m_fetch = RPC;
  int          m_drop = 0;
  bit          m_run = 0;

  logic [31:0] acc_log[$];
  logic [31:0] con_log[$];
  int          con_cyc[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic step();
    bit exp_rv, rf, rs, pp;
    logic [31:0] a;
    if (!reset) begin
      checks += 5;
      if (req_vld !== 1'b0)  begin errors++; $display("FAIL rst_req_vld got %b want 0", req_vld); end
      if (rsp_ack !== 1'b0)  begin errors++; $display("FAIL rst_rsp_ack got %b want 0", rsp_ack); end
      if (inst_vld !== 1'b0) begin errors++; $display("FAIL rst_inst_vld got %b want 0", inst_vld); end
      if (req_addr !== RPC)  begin errors++; $display("FAIL rst_req_addr got %h want %h", req_addr, RPC); end
      if (inst_pc !== 32'h0 || inst_data !== 32'h0) begin
        errors++; $display("FAIL rst_inst got %h/%h want 0/0", inst_pc, inst_data);
      end
      req_ack = 0; inst_ack = 0; rsp_vld = 0;
      @(posedge clock); edge_n++; @(negedge clock); redirect_vld = 0;
      return;
    end
    req_ack  = ($urandom_range(99) < ack_pct);
    inst_ack = ($urandom_range(99) < iack_pct);
    rs = !hold_rsp && pend_addr.size() != 0 && pend_due[0] <= edge_n;
    rsp_vld  = rs;
    rsp_addr = rs ? pend_addr[0] : $urandom;
    rsp_data = rs ? word_of(pend_addr[0]) : $urandom;

    exp_rv = m_run && (pend_addr.size() + m_q.size() < QD);
    checks += 3;
    if (req_vld !== exp_rv) begin errors++; $display("FAIL req_vld got %b want %b", req_vld, exp_rv); end
    if (rsp_ack !== m_run)  begin errors++; $display("FAIL rsp_ack got %b want %b", rsp_ack, m_run); end
    if (inst_vld !== (m_q.size() != 0)) begin
      errors++; $display("FAIL inst_vld got %b want %b", inst_vld, m_q.size() != 0);
    end
    if (req_vld === 1'b1) begin
      checks++;
      if (req_addr !== m_fetch) begin errors++; $display("FAIL req_addr got %h want %h", req_addr, m_fetch); end
    end
    if (m_q.size() != 0) begin
      checks += 2;
      if (inst_pc !== m_q[0]) begin errors++; $display("FAIL inst_pc got %h want %h", inst_pc, m_q[0]); end
      if (inst_data !== word_of(m_q[0])) begin
        errors++; $display("FAIL inst_data got %h want %h", inst_data, word_of(m_q[0]));
      end
    end

    pp = (inst_vld === 1'b1) && inst_ack;
    if (pp && m_q.size() != 0) begin
      con_log.push_back(m_q[0]); con_cyc.push_back(edge_n);
      void'(m_q.pop_front());
    end
    rf = (req_vld === 1'b1) && req_ack;
    if (rf) begin
      pend_addr.push_back(req_addr);
      pend_due.push_back(edge_n + int'($urandom_range(lat_max, lat_min)));
      acc_log.push_back(req_addr);
      m_fetch = m_fetch + 32'd4;
    end
    if (rs) begin
      a = pend_addr.pop_front(); void'(pend_due.pop_front());
      if (m_drop > 0 || redirect_vld) begin
        if (m_drop > 0) m_drop--;
      end else m_q.push_back(a);
    end
    if (redirect_vld) begin
      m_q.delete();
      m_drop  = pend_addr.size();
      m_fetch = {redirect_addr[31:2], 2'b00};
    end
    m_run = 1;
    @(posedge clock); edge_n++; @(negedge clock); redirect_vld = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step();
    checks += 2;
    if (req_rnw !== 1'b1)   begin errors++; $display("FAIL req_rnw got %b want 1", req_rnw); end
    if (req_data !== 32'h0) begin errors++; $display("FAIL req_data got %h want 0", req_data); end
    reset = 1;
    step();
    checks++;
    if (req_vld !== 1'b1 || req_addr !== RPC) begin
      errors++; $display("FAIL first_fetch got %b/%h want 1/%h", req_vld, req_addr, RPC);
    end
  endtask

  task automatic test_stream();
    ack_pct = 100; iack_pct = 100; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (con_log.size() < 20) begin
      errors++; $display("FAIL stream_count got %0d want >=20", con_log.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks += 2;
        if (con_log[i] !== RPC + 32'(4 * i)) begin
          errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, con_log[i], RPC + 32'(4 * i));
        end
        if (con_cyc[i] - con_cyc[0] != i) begin
          errors++; $display("FAIL stream_gap[%0d] got %0d want %0d", i, con_cyc[i] - con_cyc[0], i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    iack_pct = 0;
    redirect_vld = 1; redirect_addr = 32'h0;
    step();
    acc_log.delete();
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (acc_log.size() != 4) begin
      errors++; $display("FAIL bp_req_count got %0d want 4", acc_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_log[i] !== 32'(4 * i)) begin
          errors++; $display("FAIL bp_req_addr[%0d] got %h want %h", i, acc_log[i], 32'(4 * i));
        end
      end
    end
    checks += 2;
    if (req_vld !== 1'b0)  begin errors++; $display("FAIL bp_stall got %b want 0", req_vld); end
    if (inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head got %h want 0", inst_pc); end
    iack_pct = 100; step(); iack_pct = 0;
    checks++;
    if (req_vld !== 1'b1 || req_addr !== 32'h10) begin
      errors++; $display("FAIL bp_refill got %b/%h want 1/00000010", req_vld, req_addr);
    end
    step(); step();
    checks++;
    if (req_vld !== 1'b0) begin errors++; $display("FAIL bp_restall got %b want 0", req_vld); end
  endtask

  task automatic test_redirect_inflight();
    int n = 0;
    iack_pct = 100; ack_pct = 100; lat_min = 3; lat_max = 3;
    while (pend_addr.size() != 3 && n < 40) begin step(); n++; end
    checks++;
    if (pend_addr.size() != 3) begin
      errors++; $display("FAIL rdi_setup got %0d outstanding want 3", pend_addr.size());
    end
    hold_rsp = 1; ack_pct = 0;
    redirect_vld = 1; redirect_addr = 32'h100;
    step();
    hold_rsp = 0; ack_pct = 100;
    con_log.delete();
    checks++;
    if (inst_vld !== 1'b0) begin errors++; $display("FAIL rdi_flush got %b want 0", inst_vld); end
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (con_log.size() < 2 || con_log[0] !== 32'h100 || con_log[1] !== 32'h104) begin
      errors++; $display("FAIL rdi_stream got %0d items first %h want 00000100,00000104",
                         con_log.size(), con_log.size() != 0 ? con_log[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_same_cycle();
    int n = 0;
    bit found = 0;
    ack_pct = 0;
    while (pend_addr.size() != 0 && n < 20) begin step(); n++; end
    ack_pct = 100; lat_min = 1; lat_max = 1; iack_pct = 100;
    redirect_vld = 1; redirect_addr = 32'h3C;
    step();
    con_log.delete();
    for (int i = 0; i < 10 && !found; i++) begin
      if (req_vld === 1'b1 && req_addr === 32'h40 && pend_addr.size() != 0 && pend_due[0] <= edge_n) found = 1;
      else step();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rds_setup got no 0x40 request with response want one"); end
    redirect_vld = 1; redirect_addr = 32'h203;
    step();
    checks++;
    if (req_vld !== 1'b1 || req_addr !== 32'h200) begin
      errors++; $display("FAIL rds_next_req got %b/%h want 1/00000200", req_vld, req_addr);
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (con_log.size() == 0 || con_log[0] !== 32'h200) begin
      errors++; $display("FAIL rds_first_inst got %h want 00000200", con_log.size() != 0 ? con_log[0] : 32'hx);
    end
    foreach (con_log[i]) begin
      checks++;
      if (con_log[i] === 32'h3C || con_log[i] === 32'h40) begin
        errors++; $display("FAIL rds_stale got %h want dropped", con_log[i]);
      end
    end
  endtask

  task automatic test_wrap();
    lat_min = 2; lat_max = 2;
    redirect_vld = 1; redirect_addr = 32'hFFFF_FFF8;
    step();
    acc_log.delete(); con_log.delete();
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (acc_log.size() < 4 || con_log.size() < 4) begin
      errors++; $display("FAIL wrap_count got %0d/%0d want >=4", acc_log.size(), con_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (acc_log[i] !== 32'hFFFF_FFF8 + 32'(4 * i)) begin
          errors++; $display("FAIL wrap_req[%0d] got %h want %h", i, acc_log[i], 32'hFFFF_FFF8 + 32'(4 * i));
        end
        if (con_log[i] !== 32'hFFFF_FFF8 + 32'(4 * i)) begin
          errors++; $display("FAIL wrap_inst[%0d] got %h want %h", i, con_log[i], 32'hFFFF_FFF8 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_random();
    con_log.delete();
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) begin
        ack_pct  = int'($urandom_range(100, 30));
        iack_pct = int'($urandom_range(100, 20));
      end
      if ($urandom_range(99) < 3) begin
        redirect_vld = 1; redirect_addr = $urandom;
      end
      step();
    end
    checks++;
    if (con_log.size() < 200) begin
      errors++; $display("FAIL rand_progress got %0d instructions want >=200", con_log.size());
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    ack_pct = 100; iack_pct = 0; lat_min = 2; lat_max = 2;
    while (m_q.size() != QD && n < 40) begin step(); n++; end
    checks++;
    if (m_q.size() != QD) begin errors++; $display("FAIL ar_setup got %0d queued want %0d", m_q.size(), QD); end
    #2 reset = 0;
    #1;
    checks += 4;
    if (inst_vld !== 1'b0) begin errors++; $display("FAIL ar_inst_vld got %b want 0", inst_vld); end
    if (req_vld !== 1'b0)  begin errors++; $display("FAIL ar_req_vld got %b want 0", req_vld); end
    if (rsp_ack !== 1'b0)  begin errors++; $display("FAIL ar_rsp_ack got %b want 0", rsp_ack); end
    if (req_addr !== RPC)  begin errors++; $display("FAIL ar_req_addr got %h want %h", req_addr, RPC); end
    pend_addr.delete(); pend_due.delete(); m_q.delete();
    m_drop = 0; m_fetch = RPC; m_run = 0;
    @(negedge clock);
    step(); step();
    reset = 1;
    step();
    checks += 2;
    if (req_vld !== 1'b1 || req_addr !== RPC) begin
      errors++; $display("FAIL ar_restart got %b/%h want 1/%h", req_vld, req_addr, RPC);
    end
    if (inst_vld !== 1'b0) begin errors++; $display("FAIL ar_empty got %b want 0", inst_vld); end
    iack_pct = 100;
    con_log.delete();
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (con_log.size() == 0 || con_log[0] !== RPC) begin
      errors++; $display("FAIL ar_first_inst got %h want %h", con_log.size() != 0 ? con_log[0] : 32'hx, RPC);
    end
  endtask

  initial begin
    reset = 0; redirect_vld = 0; redirect_addr = 0;
    req_ack = 0; rsp_vld = 0; rsp_addr = 0; rsp_data = 0; inst_ack = 0;
    @(negedge clock);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
